game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_pkg.sv | 14 +
 rtl/rise_detect.sv | 21 ++
 rtl/game_ctrl.sv | 103 ++++++++++
 tb/tb_game_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and default constants for the whack-a-mole game controller.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } game_state_t;

    localparam int TICK_DIV_DEFAULT     = 100_000_000;
    localparam int GAME_SECONDS_DEFAULT = 60;
    localparam int SCORE_MAX_DEFAULT    = 99;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector; prev resets high so a level held through reset gives no pulse.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/game_ctrl.sv
// Game controller: start/restart, one-second countdown and saturating hit score.
module game_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV     = TICK_DIV_DEFAULT,
    parameter int GAME_SECONDS = GAME_SECONDS_DEFAULT,
    parameter int SCORE_MAX    = SCORE_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hit,
    output logic [7:0] timer_value,
    output logic [7:0] score_value,
    output logic       game_active,
    output logic       game_over,
    output logic       sec_tick
);

    localparam int               PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [7:0]       TIMER_INIT = 8'(GAME_SECONDS);
    localparam logic [7:0]       SCORE_TOP  = 8'(SCORE_MAX);

    if (GAME_SECONDS < 1 || GAME_SECONDS > 99) begin : g_bad_game_seconds
        $error("game_ctrl: GAME_SECONDS must be in 1..99");
    end
    if (SCORE_MAX < 1 || SCORE_MAX > 99) begin : g_bad_score_max
        $error("game_ctrl: SCORE_MAX must be in 1..99");
    end
    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("game_ctrl: TICK_DIV must be at least 1");
    end

    game_state_t   state, state_nxt;
    logic [PW-1:0] prescaler;
    logic          start_rise;
    logic          hit_rise;
    logic          tick_now;

    rise_detect u_start_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (start),
        .pulse (start_rise)
    );

    rise_detect u_hit_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .level (hit),
        .pulse (hit_rise)
    );

    assign tick_now    = (state == PLAY) && (prescaler == PRE_LAST);
    assign game_active = (state == PLAY);
    assign game_over   = (state == OVER);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, OVER: if (start_rise) state_nxt = PLAY;
            PLAY:       if (tick_now && timer_value <= 8'd1) state_nxt = OVER;
            default:    state_nxt = IDLE;
        endcase
    end

    // The final 1->0 tick still pulses sec_tick, so it lands in the first OVER cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler   <= '0;
            timer_value <= TIMER_INIT;
            score_value <= '0;
            sec_tick    <= 1'b0;
        end else begin
            sec_tick <= tick_now;
            if (state != PLAY) begin
                prescaler <= '0;
                if (start_rise) begin
                    timer_value <= TIMER_INIT;
                    score_value <= '0;
                end
            end else begin
                prescaler <= tick_now ? '0 : prescaler + PW'(1);
                if (tick_now) begin
                    timer_value <= timer_value - 8'd1;
                end
                if (hit_rise && score_value < SCORE_TOP) begin
                    score_value <= score_value + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: cycle-level behavioural model plus directed literal checks.
module tb_game_ctrl;

    localparam int TD = 4;
    localparam int GS = 3;
    localparam int SM = 5;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       hit;
    logic [7:0] timer_value;
    logic [7:0] score_value;
    logic       game_active;
    logic       game_over;
    logic       sec_tick;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: game phase as flags, cycles elapsed since the start edge.
    int m_timer   = GS;
    int m_score   = 0;
    int m_active  = 0;
    int m_over    = 0;
    int m_tick    = 0;
    int m_elapsed = 0;
    int m_pstart  = 1;
    int m_phit    = 1;

    game_ctrl #(
        .TICK_DIV     (TD),
        .GAME_SECONDS (GS),
        .SCORE_MAX    (SM)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .hit         (hit),
        .timer_value (timer_value),
        .score_value (score_value),
        .game_active (game_active),
        .game_over   (game_over),
        .sec_tick    (sec_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_timer = GS; m_score = 0; m_active = 0; m_over = 0;
                m_tick = 0; m_elapsed = 0; m_pstart = 1; m_phit = 1;
            end else begin
                int sr, hr;
                sr = (start && !m_pstart) ? 1 : 0;
                hr = (hit && !m_phit) ? 1 : 0;
                m_pstart = int'(start);
                m_phit   = int'(hit);
                m_tick   = 0;
                if (m_active == 0) begin
                    if (sr == 1) begin
                        m_active = 1; m_over = 0; m_timer = GS; m_score = 0; m_elapsed = 0;
                    end
                end else begin
                    m_elapsed++;
                    if (hr == 1 && m_score < SM) m_score++;
                    if (m_elapsed % TD == 0) begin
                        m_tick = 1;
                        m_timer--;
                        if (m_timer == 0) begin
                            m_active = 0;
                            m_over   = 1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("model_timer", int'(timer_value), m_timer);
            check("model_score", int'(score_value), m_score);
            check("model_active", int'(game_active), m_active);
            check("model_over", int'(game_over), m_over);
            check("model_tick", int'(sec_tick), m_tick);
        end
    end

    task automatic hit_pulse();
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        hit   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_timer", int'(timer_value), 3);
        check("rst_score", int'(score_value), 0);
        check("rst_active", int'(game_active), 0);
        check("rst_over", int'(game_over), 0);
        check("rst_tick", int'(sec_tick), 0);
        rst_n = 1'b1;

        // Game 1: plain countdown 3->2->1->0 at 4-cycle spacing.
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("g1_active", int'(game_active), 1);
        check("g1_timer3", int'(timer_value), 3);
        repeat (4) @(negedge clk);
        check("g1_timer2", int'(timer_value), 2);
        check("g1_tick2", int'(sec_tick), 1);
        repeat (4) @(negedge clk);
        check("g1_timer1", int'(timer_value), 1);
        repeat (4) @(negedge clk);
        check("g1_timer0", int'(timer_value), 0);
        check("g1_over", int'(game_over), 1);
        check("g1_active_end", int'(game_active), 0);
        @(negedge clk);
        check("g1_tick_off", int'(sec_tick), 0);

        // Game 2: restart from OVER, then hits saturate at SCORE_MAX.
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("g2_restart_active", int'(game_active), 1);
        check("g2_restart_timer", int'(timer_value), 3);
        check("g2_restart_score", int'(score_value), 0);
        hit_pulse();
        check("g2_score1", int'(score_value), 1);
        repeat (4) hit_pulse();
        check("g2_score5", int'(score_value), 5);
        hit_pulse();
        check("g2_score_sat", int'(score_value), 5);
        check("g2_over", int'(game_over), 1);
        hit_pulse();
        check("g2_score_over_hold", int'(score_value), 5);

        // Game 3: start ignored in PLAY; hit coinciding with final tick.
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("g3_midstart_timer", int'(timer_value), 3);
        check("g3_midstart_active", int'(game_active), 1);
        repeat (8) @(negedge clk);
        hit = 1'b1;
        @(negedge clk); hit = 1'b0;
        check("g3_final_hit_score", int'(score_value), 1);
        check("g3_final_over", int'(game_over), 1);
        check("g3_final_timer", int'(timer_value), 0);
        @(negedge clk);
        hit_pulse();
        check("g3_late_hit", int'(score_value), 1);

        // Game 4: asynchronous reset mid-play with score 2.
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        hit_pulse();
        hit_pulse();
        check("g4_score2", int'(score_value), 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_timer", int'(timer_value), 3);
        check("arst_score", int'(score_value), 0);
        check("arst_active", int'(game_active), 0);
        check("arst_over", int'(game_over), 0);
        check("arst_tick", int'(sec_tick), 0);

        // Start held through reset release must not start a game.
        start = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("held_start_idle", int'(game_active), 0);
        start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        check("repress_active", int'(game_active), 1);
        check("repress_timer", int'(timer_value), 3);
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
